imem_loader: RTL and testbench

- Write-side counterpart of the instruction fetch path. The fetch stage only ever reads instruction memory; this block fills that memory.
- Accepts a byte stream over a valid/ready handshake, parses a 2-byte word-count header, and assembles little-endian 32-bit instruction words.
- Writes each word to sequential instruction-memory word addresses starting at 0.
- Holds the processor (PC enable low) until the load finishes cleanly.

---
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader: parses a 2-byte word-count header from a byte stream and writes little-endian
// 32-bit words to sequential instruction-memory addresses, holding the CPU until done.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [15:0] n_q, n_d, n_new, words_inc;
  logic [1:0] idx_q, idx_d;
  logic [DATA_W-1:0] asm_q, asm_d, wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0] words_q, words_d;
  logic byte_ready_q, byte_ready_d, wr_en_q, wr_en_d, cpu_hold_q, cpu_hold_d;
  logic done_q, done_d, err_q, err_d, xfer;
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    idx_d = idx_q;
    asm_d = asm_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    words_d = words_q;
    xfer = byte_valid && byte_ready_q;
    n_new = {byte_in, n_q[7:0]};
    words_inc = 16'(words_q) + 16'd1;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = HDR0;
        wr_addr_d = '0;
        words_d = '0;
      end
      HDR0: if (xfer) begin
        n_d[7:0] = byte_in;
        state_d = HDR1;
      end
      HDR1: if (xfer) begin
        n_d = n_new;
        state_d = (n_new == 16'd0 || 32'(n_new) > (32'd1 << ADDR_W)) ? ERR : DATA;
      end
      DATA: if (xfer) begin
        asm_d[{idx_q, 3'b000} +: 8] = byte_in;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = WRITE;
          wr_data_d = asm_d;
        end
      end
      WRITE: begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
        words_d = words_q + (ADDR_W+1)'(1);
        state_d = (words_inc == n_q) ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered, so they follow the state being entered
    byte_ready_d = state_d inside {HDR0, HDR1, DATA};
    wr_en_d = state_d == WRITE;
    cpu_hold_d = state_d != DONE;
    done_d = state_d == DONE;
    err_d = state_d == ERR;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q <= '0;
      idx_q <= '0;
      asm_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      words_q <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      idx_q <= idx_d;
      asm_q <= asm_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      words_q <= words_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q <= wr_en_d;
      cpu_hold_q <= cpu_hold_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign byte_ready = byte_ready_q;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done = done_q;
  assign err = err_q;
  assign words_written = words_q;
endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// tb_imem_loader: table-driven and randomized loads checked against a word-level model
// of the expected memory image, plus hand-written reset/restart sequences.
module tb_imem_loader;
  localparam int AW = 10;
  logic clk = 0, reset = 0, start = 0, byte_valid = 0;
  logic [7:0] byte_in = 0;
  logic byte_ready, wr_en, cpu_hold, done, err;
  logic [AW-1:0] wr_addr;
  logic [31:0] wr_data;
  logic [AW:0] words_written;

  imem_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int got_a[$];
  logic [31:0] got_d[$], exp_d[$];
  typedef struct {logic [15:0] n; bit bad; int gap;} vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) if (wr_en) begin
    got_a.push_back(int'(wr_addr));
    got_d.push_back(wr_data);
    chk("ready_in_write", byte_ready, 0);
  end

  task automatic send(input logic [7:0] b, input int gapmax);
    int n;
    logic acc;
    byte_valid = 0;
    repeat (int'($urandom_range(0, gapmax))) begin
      byte_in = 8'($urandom);
      @(negedge clk);
    end
    byte_in = b;
    byte_valid = 1;
    for (n = 0; n < 50; n++) begin
      acc = byte_ready;
      @(negedge clk);
      if (acc) break;
    end
    byte_valid = 0;
    if (n == 50) chk("send_timeout", 0, 1);
  endtask

  task automatic do_start;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic feed(input logic [15:0] n, input bit legal, input int g);
    send(n[7:0], g);
    send(n[15:8], g);
    if (legal) foreach (exp_d[k]) for (int j = 0; j < 4; j++) send(exp_d[k][8*j +: 8], g);
  endtask

  task automatic check_load(input string nm, input logic [15:0] n, input bit legal);
    int i, ec;
    for (i = 0; i < 100 && !(done || err); i++) @(negedge clk);
    chk({nm, "_finished"}, done | err, 1);
    ec = legal ? exp_d.size() : 0;
    chk({nm, "_done"}, done, legal);
    chk({nm, "_err"}, err, !legal);
    chk({nm, "_hold"}, cpu_hold, !legal);
    chk({nm, "_words"}, words_written, legal ? n : 0);
    chk({nm, "_addr_end"}, wr_addr, legal ? (n % 1024) : 0);
    chk({nm, "_nwrites"}, got_a.size(), ec);
    for (int k = 0; k < got_a.size() && k < ec; k++) begin
      chk($sformatf("%s_waddr%0d", nm, k), got_a[k], k);
      chk($sformatf("%s_wdata%0d", nm, k), got_d[k], exp_d[k]);
    end
    got_a.delete();
    got_d.delete();
  endtask

  task automatic run(input string nm, input logic [15:0] n, input bit legal, input int g);
    do_start;
    feed(n, legal, g);
    check_load(nm, n, legal);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, byte_ready, 0);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_wr_addr"}, wr_addr, 0);
    chk({nm, "_wr_data"}, wr_data, 0);
    chk({nm, "_hold"}, cpu_hold, 1);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_words"}, words_written, 0);
  endtask

  initial begin
    logic [15:0] n;
    bit legal;
    tbl[0] = '{16'd2, 1'b0, 0};
    tbl[1] = '{16'd0, 1'b1, 0};
    tbl[2] = '{16'd1025, 1'b1, 1};
    tbl[3] = '{16'd1, 1'b0, 3};
    tbl[4] = '{16'd7, 1'b0, 1};
    tbl[5] = '{16'hFFFF, 1'b1, 2};
    tbl[6] = '{16'd3, 1'b0, 2};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1;
    @(negedge clk);
    chk("idle_ready", byte_ready, 0);

    exp_d = '{32'h00000013, 32'h00100093};
    run("basic", 16'd2, 1, 0);

    byte_valid = 1;
    byte_in = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("done_ready", byte_ready, 0);
    end
    byte_valid = 0;
    chk("done_words_kept", words_written, 2);
    chk("done_kept", done, 1);

    do_start;
    chk("reload_hold", cpu_hold, 1);
    chk("reload_done", done, 0);
    exp_d = '{32'hCAFEF00D};
    feed(16'd1, 1, 0);
    check_load("reload", 16'd1, 1);

    exp_d = '{32'h00000013, 32'h00100093};
    run("gaps", 16'd2, 1, 3);

    run("zero_hdr", 16'd0, 0, 0);
    run("n1025", 16'd1025, 0, 0);
    exp_d = '{32'hDDCCBBAA};
    run("recover", 16'd1, 1, 0);

    foreach (tbl[t]) begin
      exp_d.delete();
      if (!tbl[t].bad) repeat (int'(tbl[t].n)) exp_d.push_back($urandom);
      run($sformatf("tbl%0d", t), tbl[t].n, !tbl[t].bad, tbl[t].gap);
    end

    for (int i = 0; i < 12; i++) begin
      n = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 4) == 0) n = 16'($urandom_range(1025, 65535));
      legal = n != 0 && n <= 1024;
      exp_d.delete();
      if (legal) repeat (int'(n)) exp_d.push_back($urandom);
      run($sformatf("rnd%0d", i), n, legal, 3);
    end

    exp_d.delete();
    for (int k = 0; k < 1024; k++) exp_d.push_back(32'(k));
    run("full", 16'd1024, 1, 0);

    exp_d = '{32'h44332211};
    do_start;
    send(8'h04, 0);
    send(8'h00, 0);
    foreach (exp_d[k]) for (int j = 0; j < 4; j++) send(exp_d[k][8*j +: 8], 0);
    send(8'h55, 0);
    do_start;
    send(8'h66, 0);
    @(negedge clk);
    chk("midrst_nwrites", got_a.size(), 1);
    if (got_a.size() > 0) begin
      chk("midrst_waddr", got_a[0], 0);
      chk("midrst_wdata", got_d[0], 32'h44332211);
    end
    chk("midrst_words", words_written, 1);
    got_a.delete();
    got_d.delete();
    reset = 0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    start = 1;
    byte_valid = 1;
    byte_in = 8'h01;
    @(negedge clk);
    start = 0;
    byte_valid = 0;
    exp_d = '{32'h0BADBEEF};
    feed(16'd1, 1, 0);
    check_load("after_rst", 16'd1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
